fetch_sequencer: RTL and testbench

//  Control FSM for the instruction-fetch stage. Owns the program counter and schedules

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control FSM. It owns the program counter and
// sequences PC+4 fetch, branch redirects with a fixed IF/ID flush window, hazard
// stalls and halt/resume. It also keeps saturating stall and flush counters.
module fetch_sequencer #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hazard_stall,
   input  logic              br_taken,
   input  logic [31:0]       br_addr,
   input  logic              halt_req,
   output logic [31:0]       pc,
   output logic              ifid_en,
   output logic              if_flush,
   output logic              halted,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int FW = $clog2(FLUSH_CYCLES) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [FW-1:0]     fcnt_q, fcnt_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;
   logic              stall_inc;

   // State, pc, flush window and counters; synchronous active-low reset wins over everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         fcnt_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fcnt_q  <= fcnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   // Next-state and flush-window countdown; RUN priority is branch > halt > stall
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (br_taken) begin
               if (FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  fcnt_d  = FW'(FLUSH_CYCLES - 1);
               end
            end else if (halt_req) begin
               state_d = HALT;
            end
         end
         FLUSH: begin
            // wrong-path cycles: branch, stall and halt requests are not looked at
            fcnt_d = fcnt_q - 1'b1;
            if (fcnt_q == FW'(1)) state_d = RUN;
         end
         HALT: if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // IF/ID controls and next pc, combinational from state and inputs
   always_comb begin
      ifid_en   = 1'b0;
      if_flush  = 1'b0;
      halted    = 1'b0;
      stall_inc = 1'b0;
      pc_d      = pc_q;
      case (state_q)
         RUN: begin
            if (br_taken) begin
               ifid_en  = 1'b1;
               if_flush = 1'b1;
               pc_d     = br_addr & 32'hFFFF_FFFC;
            end else if (halt_req) begin
               // one NOP enters IF/ID, the fetch address is held for resume
               ifid_en  = 1'b1;
               if_flush = 1'b1;
            end else if (hazard_stall) begin
               stall_inc = 1'b1;
            end else begin
               ifid_en = 1'b1;
               pc_d    = pc_q + 32'd4;
            end
         end
         FLUSH: begin
            ifid_en  = 1'b1;
            if_flush = 1'b1;
            pc_d     = pc_q + 32'd4;
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

   // Saturating counters: every applied stall and every flushed IF/ID load
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
      if (if_flush  && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + 1'b1;
   end

   assign pc          = pc_q;
   assign state       = state_q;
   assign stall_count = stall_q;
   assign flush_count = flush_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=3/CNT_W=4) share stimulus and are tracked by a cycle model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, hazard_stall, br_taken, halt_req;
   logic [31:0] br_addr;

   logic [31:0] pc0, pc1;
   logic        en0, fl0, hl0, en1, fl1, hl1;
   logic [1:0]  st0, st1;
   logic [15:0] sc0, fc0;
   logic [3:0]  sc1, fc1;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .start(start), .hazard_stall(hazard_stall),
      .br_taken(br_taken), .br_addr(br_addr), .halt_req(halt_req),
      .pc(pc0), .ifid_en(en0), .if_flush(fl0), .halted(hl0), .state(st0),
      .stall_count(sc0), .flush_count(fc0));

   fetch_sequencer #(.FLUSH_CYCLES(3), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .start(start), .hazard_stall(hazard_stall),
      .br_taken(br_taken), .br_addr(br_addr), .halt_req(halt_req),
      .pc(pc1), .ifid_en(en1), .if_flush(fl1), .halted(hl1), .state(st1),
      .stall_count(sc1), .flush_count(fc1));

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 run, 2 flushing (left = wrong-path cycles still to go), 3 halted
   typedef struct {
      int          mode;
      int          left;
      logic [31:0] pc;
      int          stalls;
      int          flushes;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t mreset();
      mdl_t m;
      m.mode = 0; m.left = 0; m.pc = 32'd0; m.stalls = 0; m.flushes = 0;
      return m;
   endfunction

   // {ifid_en, if_flush, halted} for the current inputs
   function automatic logic [2:0] mout(mdl_t m);
      if (m.mode == 1) begin
         if (br_taken || halt_req) return 3'b110;
         if (hazard_stall)         return 3'b000;
         return 3'b100;
      end
      if (m.mode == 2) return 3'b110;
      if (m.mode == 3) return 3'b001;
      return 3'b000;
   endfunction

   function automatic mdl_t mnext(mdl_t m, int fc, int cw);
      mdl_t n = m;
      logic [2:0] o = mout(m);
      int cmax = (1 << cw) - 1;
      if (!rst) return mreset();
      if (o[1] && m.flushes < cmax) n.flushes = m.flushes + 1;
      case (m.mode)
         0: if (start) n.mode = 1;
         1: if (br_taken) begin
               n.pc   = {br_addr[31:2], 2'b00};
               n.left = fc - 1;
               n.mode = (fc > 1) ? 2 : 1;
            end else if (halt_req) n.mode = 3;
            else if (hazard_stall) begin
               if (m.stalls < cmax) n.stalls = m.stalls + 1;
            end else n.pc = m.pc + 32'd4;
         2: begin
               n.pc   = m.pc + 32'd4;
               n.left = m.left - 1;
               if (n.left == 0) n.mode = 1;
            end
         default: if (start) n.mode = 1;
      endcase
      return n;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic pre(input logic r, input logic s, input logic hz, input logic br,
                      input logic [31:0] ba, input logic h);
      rst = r; start = s; hazard_stall = hz; br_taken = br; br_addr = ba; halt_req = h;
      #2;
   endtask

   // compare both instances with the model, then clock once
   task automatic post();
      logic [2:0] o0 = mout(m0);
      logic [2:0] o1 = mout(m1);
      chk("d0.pc",    pc0, m0.pc);
      chk("d0.state", 32'(st0), 32'(m0.mode));
      chk("d0.ctl",   32'({en0, fl0, hl0}), 32'(o0));
      chk("d0.stall", 32'(sc0), 32'(m0.stalls));
      chk("d0.flush", 32'(fc0), 32'(m0.flushes));
      chk("d1.pc",    pc1, m1.pc);
      chk("d1.state", 32'(st1), 32'(m1.mode));
      chk("d1.ctl",   32'({en1, fl1, hl1}), 32'(o1));
      chk("d1.stall", 32'(sc1), 32'(m1.stalls));
      chk("d1.flush", 32'(fc1), 32'(m1.flushes));
      @(posedge clk);
      m0 = mnext(m0, 2, 16);
      m1 = mnext(m1, 3, 4);
      @(negedge clk);
   endtask

   task automatic step(input logic r, input logic s, input logic hz, input logic br,
                       input logic [31:0] ba, input logic h);
      pre(r, s, hz, br, ba, h);
      post();
   endtask

   // redirect dut0 so that it is in RUN at address a (branch to a-4, one flush cycle)
   task automatic goto_run(input logic [31:0] a);
      step(1, 0, 0, 1, a - 32'd4, 0);
      step(1, 0, 0, 0, 32'd0, 0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        r, s, hz, br, h;
      logic [31:0] ba;
      logic [31:0] pc;
      logic [1:0]  st;
      logic        en, fl;
   } vec_t;

   vec_t tbl[8];
   logic [15:0] base;

   initial begin
      tbl[0] = '{r:1, s:1, hz:0, br:0, h:0, ba:32'h0,   pc:32'h0,   st:2'd0, en:0, fl:0};
      tbl[1] = '{r:1, s:0, hz:0, br:0, h:0, ba:32'h0,   pc:32'h0,   st:2'd1, en:1, fl:0};
      tbl[2] = '{r:1, s:0, hz:0, br:0, h:0, ba:32'h0,   pc:32'h4,   st:2'd1, en:1, fl:0};
      tbl[3] = '{r:1, s:0, hz:0, br:0, h:0, ba:32'h0,   pc:32'h8,   st:2'd1, en:1, fl:0};
      tbl[4] = '{r:1, s:0, hz:0, br:0, h:0, ba:32'h0,   pc:32'hC,   st:2'd1, en:1, fl:0};
      tbl[5] = '{r:1, s:0, hz:0, br:1, h:0, ba:32'h13E, pc:32'h10,  st:2'd1, en:1, fl:1};
      tbl[6] = '{r:1, s:0, hz:0, br:0, h:0, ba:32'h0,   pc:32'h13C, st:2'd2, en:1, fl:1};
      tbl[7] = '{r:1, s:0, hz:0, br:0, h:0, ba:32'h0,   pc:32'h140, st:2'd1, en:1, fl:0};

      // reset out of unknown state
      @(negedge clk);
      pre(0, 0, 0, 0, 32'd0, 0);
      @(posedge clk);
      m0 = mreset(); m1 = mreset();
      @(negedge clk);
      step(0, 1, 1, 1, 32'hFFFF_FFFF, 1);
      chk("rst.pc", pc0, 32'd0);
      chk("rst.state", 32'(st0), 32'd0);
      chk("rst.counts", {sc0, fc0}, 32'd0);

      // bring-up and first branch
      foreach (tbl[i]) begin
         pre(tbl[i].r, tbl[i].s, tbl[i].hz, tbl[i].br, tbl[i].ba, tbl[i].h);
         chk($sformatf("vec%0d.pc", i), pc0, tbl[i].pc);
         chk($sformatf("vec%0d.state", i), 32'(st0), 32'(tbl[i].st));
         chk($sformatf("vec%0d.en_fl", i), 32'({en0, fl0}), 32'({tbl[i].en, tbl[i].fl}));
         post();
      end
      chk("br.flush_count", 32'(fc0), 32'd2);

      // branch beats a simultaneous stall; stall during FLUSH is ignored
      base = sc0;
      step(1, 0, 1, 1, 32'h200, 0);
      chk("brstall.pc", pc0, 32'h200);
      pre(1, 0, 1, 0, 32'd0, 0);
      chk("flushstall.en", 32'(en0), 32'd1);
      post();
      chk("flushstall.pc", pc0, 32'h204);
      chk("brstall.stall_count", 32'(sc0), 32'(base));

      // three stall cycles at 0x20
      goto_run(32'h20);
      base = sc0;
      for (int k = 0; k < 3; k++) begin
         pre(1, 0, 1, 0, 32'd0, 0);
         chk($sformatf("stall%0d.pc", k), pc0, 32'h20);
         chk($sformatf("stall%0d.en", k), 32'(en0), 32'd0);
         post();
      end
      chk("stall.count", 32'(sc0 - base), 32'd3);
      step(1, 0, 0, 0, 32'd0, 0);
      chk("stall.after_pc", pc0, 32'h24);

      // halt at 0x1C8, ignored requests while halted, resume
      goto_run(32'h1C8);
      pre(1, 0, 0, 0, 32'd0, 1);
      chk("halt.nop", 32'({en0, fl0}), 32'b11);
      post();
      pre(1, 0, 1, 1, 32'h400, 0);
      chk("halt.halted", 32'(hl0), 32'd1);
      post();
      chk("halt.pc_held", pc0, 32'h1C8);
      step(1, 1, 0, 0, 32'd0, 0);
      pre(1, 0, 0, 0, 32'd0, 0);
      chk("resume.pc", pc0, 32'h1C8);
      chk("resume.en", 32'(en0), 32'd1);
      post();

      // reset in the middle of the flush window
      step(1, 0, 0, 1, 32'h800, 0);
      chk("midflush.state", 32'(st0), 32'd2);
      step(0, 0, 0, 0, 32'd0, 0);
      pre(1, 0, 0, 0, 32'd0, 0);
      chk("midflush.rst_pc", pc0, 32'd0);
      chk("midflush.rst_state", 32'(st0), 32'd0);
      chk("midflush.rst_counts", {sc0, fc0}, 32'd0);
      chk("midflush.rst_flush", 32'(fl0), 32'd0);
      post();

      // saturation of the 4-bit stall counter
      step(1, 1, 0, 0, 32'd0, 0);
      for (int k = 0; k < 20; k++) step(1, 0, 1, 0, 32'd0, 0);
      chk("sat.stall_count4", 32'(sc1), 32'd15);
      chk("sat.stall_count16", 32'(sc0), 32'd20);

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(63) != 0), ($urandom_range(7) == 0),
              ($urandom_range(3) == 0), ($urandom_range(5) == 0),
              ((k % 300) == 299) ? 32'hFFFF_FFFE : $urandom,
              ($urandom_range(19) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
